darkfetch: RTL

Instruction-fetch stage that drives the program-counter register and feeds decode. Each cycle it computes the next PC and its load enable. It issues word fetches at the current PC to instruction memory. Returned instructions, tagged with their PC, are buffered in a small FIFO for decode. Branch/jump redirects from execute flush the buffer and reload the PC.

---
 rtl/darkriscv_pkg.sv | 17 +
 rtl/darkfifo.sv | 56 +++++
 rtl/darkfetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/darkriscv_pkg.sv
// Shared fetch-stage types: FIFO entry layout, fetch FSM states and instruction size.
package darkriscv_pkg;

    localparam int INSN_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        BUBBLE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/darkfifo.sv
// Prefetch FIFO of {pc, insn} entries with synchronous flush; head reads as zero when empty.
module darkfifo
    import darkriscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t dout,
    output logic         valid,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    fetch_entry_t  mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left unreset; the head is masked to zero while count is zero.
    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wptr] <= din;
    end

    assign valid = (count != '0);
    assign full  = (count == FULL_COUNT);
    assign dout  = valid ? mem[rptr] : '0;

endmodule

// File: rtl/darkfetch.sv
// Instruction-fetch stage: next-PC / fetch FSM feeding decode through darkfifo.
// Optional DARKFETCH_BYPASS_EN presents a transfer directly to decode when the FIFO is empty.
module darkfetch
    import darkriscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] PC,
    output logic        EN,
    output logic [31:0] NXPC,
    output logic        IREQ,
    output logic [31:0] IADDR,
    input  logic        IACK,
    input  logic [31:0] IDATA,
    input  logic        REDIR,
    input  logic [31:0] REDIR_PC,
    output logic        OVALID,
    input  logic        OREADY,
    output logic [31:0] OINSN,
    output logic [31:0] OPC
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         xfer;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_valid;
    logic         fifo_full;
    fetch_entry_t fifo_din;
    fetch_entry_t fifo_dout;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) state <= IDLE;
        else     state <= state_next;
    end

    assign IADDR    = PC;
    assign fifo_pop = fifo_valid & OREADY;
    assign fifo_din = '{pc: PC, insn: IDATA};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        EN         = 1'b0;
        NXPC       = PC;
        IREQ       = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                EN         = 1'b1;
                NXPC       = RESET_PC;
                state_next = FETCH;
            end
            FETCH: begin
                // Using the FIFO's own pop keeps IREQ independent of IACK in bypass builds.
                IREQ = !fifo_full || fifo_pop;
                xfer = IREQ && IACK;
                if (xfer) begin
                    EN   = 1'b1;
                    NXPC = PC + 32'(INSN_BYTES);
                end
            end
            BUBBLE:  state_next = FETCH;
            default: state_next = IDLE;
        endcase
        if (REDIR) begin
            EN         = 1'b1;
            NXPC       = REDIR_PC;
            state_next = BUBBLE;
        end
        if (RES) begin
            EN   = 1'b1;
            NXPC = RESET_PC;
            IREQ = 1'b0;
        end
    end

`ifdef DARKFETCH_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass    = xfer && !REDIR && !fifo_valid;
        fifo_push = xfer && !REDIR && !(bypass && OREADY);
        OVALID    = fifo_valid || bypass;
        OINSN     = bypass ? IDATA : fifo_dout.insn;
        OPC       = bypass ? PC    : fifo_dout.pc;
    end
`else
    always_comb begin
        fifo_push = xfer && !REDIR;
        OVALID    = fifo_valid;
        OINSN     = fifo_dout.insn;
        OPC       = fifo_dout.pc;
    end
`endif

    darkfifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK  (CLK),
        .RES  (RES),
        .flush(REDIR),
        .push (fifo_push),
        .din  (fifo_din),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .valid(fifo_valid),
        .full (fifo_full)
    );

endmodule
